// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural flag register, one-cycle
// branch redirect, overflow/underflow trap tracking and an EX forwarding tap.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLAG_WIDTH     = 3,
  parameter int OVF_CNT_WIDTH  = 8,
  parameter int TRAP_ON_OVF    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [DATA_WIDTH-1:0]     ex_pc,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [FLAG_WIDTH-1:0]     ex_flag,
  input  logic                      ex_flag_we,
  input  logic                      ex_branch,
  input  logic [DATA_WIDTH-1:0]     ex_branch_target,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [DATA_WIDTH-1:0]     mem_pc,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      mem_exception,
  output logic [FLAG_WIDTH-1:0]     flag_reg,
  output logic                      redirect,
  output logic [DATA_WIDTH-1:0]     redirect_target,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic [OVF_CNT_WIDTH-1:0]  ovf_count
);

  localparam logic [FLAG_WIDTH-1:0] FLAG_OVERFLOW  = FLAG_WIDTH'(3);
  localparam logic [FLAG_WIDTH-1:0] FLAG_UNDERFLOW = FLAG_WIDTH'(4);
  localparam logic                  TRAP_EN        = (TRAP_ON_OVF != 0);

  logic                      valid_q,  valid_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [DATA_WIDTH-1:0]     store_q,  store_d;
  logic [DATA_WIDTH-1:0]     pc_q,     pc_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;
  logic                      rw_q,     rw_d;
  logic                      mr_q,     mr_d;
  logic                      mw_q,     mw_d;
  logic                      exc_q,    exc_d;
  logic [FLAG_WIDTH-1:0]     flag_q,   flag_d;
  logic                      redir_q,  redir_d;
  logic [DATA_WIDTH-1:0]     target_q, target_d;
  logic [OVF_CNT_WIDTH-1:0]  cnt_q,    cnt_d;

  logic accept;
  logic ovf_evt;

  assign accept  = ex_valid & ~stall & ~flush;
  assign ovf_evt = accept & ex_flag_we &
                   ((ex_flag == FLAG_OVERFLOW) | (ex_flag == FLAG_UNDERFLOW));

  // Next-state selection: flush beats stall, stall beats bubble/accept.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    pc_d     = pc_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    exc_d    = exc_q;
    flag_d   = flag_q;
    redir_d  = 1'b0;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (flush || (!stall && !ex_valid)) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      exc_d   = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = ex_result;
      store_d  = ex_store_data;
      pc_d     = ex_pc;
      rd_d     = ex_rd;
      rw_d     = ex_reg_write & ~(TRAP_EN & ovf_evt);
      mr_d     = ex_mem_read;
      mw_d     = ex_mem_write;
      exc_d    = TRAP_EN & ovf_evt;
      if (ex_branch) begin
        redir_d  = 1'b1;
        target_d = ex_branch_target;
      end
    end

    if (accept && ex_flag_we) flag_d = ex_flag;
    if (ovf_evt && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      exc_q    <= 1'b0;
      flag_q   <= '0;
      redir_q  <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      exc_q    <= exc_d;
      flag_q   <= flag_d;
      redir_q  <= redir_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output drive: controls gated by valid, forwarding tap from MEM slot.
  always_comb begin
    mem_valid       = valid_q;
    mem_result      = result_q;
    mem_store_data  = store_q;
    mem_pc          = pc_q;
    mem_rd          = rd_q;
    mem_reg_write   = valid_q & rw_q;
    mem_mem_read    = valid_q & mr_q;
    mem_mem_write   = valid_q & mw_q;
    mem_exception   = exc_q;
    flag_reg        = flag_q;
    redirect        = redir_q;
    redirect_target = target_q;
    fwd_valid       = valid_q & rw_q;
    fwd_rd          = rd_q;
    fwd_data        = result_q;
    ovf_count       = cnt_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic, checked
// against a transaction-level model. Two instances: default (8-bit counter,
// trapping) and a 2-bit counter, non-trapping variant.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush, ex_valid;
  logic [31:0] ex_result, ex_store_data, ex_pc, ex_branch_target;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_flag_we, ex_branch;
  logic [2:0]  ex_flag;

  logic        mv_a, rw_a, mr_a, mw_a, exc_a, rdr_a, fv_a;
  logic [31:0] res_a, st_a, pc_a, tgt_a, fd_a;
  logic [4:0]  rd_a, frd_a;
  logic [2:0]  flag_a;
  logic [7:0]  cnt_a;

  logic        mv_b, rw_b, mr_b, mw_b, exc_b, rdr_b, fv_b;
  logic [31:0] res_b, st_b, pc_b, tgt_b, fd_b;
  logic [4:0]  rd_b, frd_b;
  logic [2:0]  flag_b;
  logic [1:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ex_mem_stage dut_a (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_flag(ex_flag),
    .ex_flag_we(ex_flag_we), .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
    .mem_valid(mv_a), .mem_result(res_a), .mem_store_data(st_a), .mem_pc(pc_a),
    .mem_rd(rd_a), .mem_reg_write(rw_a), .mem_mem_read(mr_a), .mem_mem_write(mw_a),
    .mem_exception(exc_a), .flag_reg(flag_a), .redirect(rdr_a),
    .redirect_target(tgt_a), .fwd_valid(fv_a), .fwd_rd(frd_a), .fwd_data(fd_a),
    .ovf_count(cnt_a)
  );

  ex_mem_stage #(.OVF_CNT_WIDTH(2), .TRAP_ON_OVF(0)) dut_b (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_flag(ex_flag),
    .ex_flag_we(ex_flag_we), .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
    .mem_valid(mv_b), .mem_result(res_b), .mem_store_data(st_b), .mem_pc(pc_b),
    .mem_rd(rd_b), .mem_reg_write(rw_b), .mem_mem_read(mr_b), .mem_mem_write(mw_b),
    .mem_exception(exc_b), .flag_reg(flag_b), .redirect(rdr_b),
    .redirect_target(tgt_b), .fwd_valid(fv_b), .fwd_rd(frd_b), .fwd_data(fd_b),
    .ovf_count(cnt_b)
  );

  // Architectural view of the MEM slot after each edge.
  typedef struct {
    bit          valid;
    logic [31:0] result, store, pc, target;
    logic [4:0]  rd;
    bit          rw, mr, mw, exc, redirect;
    logic [2:0]  flag;
    int unsigned cnt;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t mstep(model_t m, int unsigned cnt_max, bit trap);
    bit acc, evt;
    model_t n;
    n = m;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    acc = ex_valid && !stall && !flush;
    evt = acc && ex_flag_we && (ex_flag == 3 || ex_flag == 4);
    n.redirect = 0;
    if (flush || (!stall && !ex_valid)) begin
      n.valid = 0;
      n.exc   = 0;
    end else if (acc) begin
      n.valid  = 1;
      n.result = ex_result;
      n.store  = ex_store_data;
      n.pc     = ex_pc;
      n.rd     = ex_rd;
      n.rw     = ex_reg_write && !(trap && evt);
      n.mr     = ex_mem_read;
      n.mw     = ex_mem_write;
      n.exc    = trap && evt;
      if (ex_branch) begin
        n.redirect = 1;
        n.target   = ex_branch_target;
      end
    end
    if (acc && ex_flag_we) n.flag = ex_flag;
    if (evt && n.cnt < cnt_max) n.cnt = n.cnt + 1;
    return n;
  endfunction

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0;
    ex_result = '0; ex_store_data = '0; ex_pc = '0; ex_branch_target = '0;
    ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_flag = '0; ex_flag_we = 0; ex_branch = 0;
  endtask

  task automatic tick();
    m_a = mstep(m_a, 255, 1'b1);
    m_b = mstep(m_b, 3, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; ex_valid = 1; ex_result = 32'hDEADBEEF; ex_reg_write = 1;
    ex_branch = 1; ex_branch_target = 32'h100; ex_flag = 3'b011; ex_flag_we = 1;
    tick(); tick();
    checks++;
    if ({mv_a, res_a, st_a, pc_a, rd_a, rw_a, mr_a, mw_a, exc_a, rdr_a, tgt_a,
         fv_a, frd_a, fd_a, cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h rdr=%b cnt=%0d, want all 0",
               mv_a, res_a, rdr_a, cnt_a);
    end
    checks++;
    if (flag_a !== 3'b000) begin
      errors++; $display("FAIL reset_flag: got %b want 000", flag_a);
    end
    idle(); reset = 0;
    ex_valid = 1; ex_result = 32'hCAFE0001;
    tick();
    checks++;
    if (mv_a !== 1'b1 || res_a !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL reset_release: got valid=%b res=%h want 1/cafe0001", mv_a, res_a);
    end
  endtask

  task automatic test_pipeline();
    idle();
    ex_valid = 1; ex_result = 32'h12345678; ex_rd = 5'd7; ex_reg_write = 1;
    ex_store_data = 32'hA5A5A5A5; ex_pc = 32'h0000_0020;
    tick();
    checks++;
    if (mv_a !== 1 || res_a !== 32'h12345678 || fv_a !== 1 || frd_a !== 5'd7 ||
        fd_a !== 32'h12345678 || st_a !== 32'hA5A5A5A5 || pc_a !== 32'h20 || rw_a !== 1) begin
      errors++;
      $display("FAIL pipeline_pass: got v=%b res=%h fv=%b frd=%0d fd=%h st=%h pc=%h rw=%b",
               mv_a, res_a, fv_a, frd_a, fd_a, st_a, pc_a, rw_a);
    end
    idle();
    tick();
    checks++;
    if (mv_a !== 0 || rw_a !== 0 || fv_a !== 0) begin
      errors++;
      $display("FAIL bubble: got v=%b rw=%b fv=%b want 0/0/0", mv_a, rw_a, fv_a);
    end
  endtask

  task automatic test_flag_branch();
    idle();
    ex_valid = 1; ex_flag = 3'b001; ex_flag_we = 1;
    tick();
    checks++;
    if (flag_a !== 3'b001) begin
      errors++; $display("FAIL cmp_flag: got %b want 001", flag_a);
    end
    idle();
    ex_valid = 1; ex_branch = 1; ex_branch_target = 32'h40;
    tick();
    checks++;
    if (rdr_a !== 1 || tgt_a !== 32'h40 || flag_a !== 3'b001) begin
      errors++;
      $display("FAIL branch_redirect: got rdr=%b tgt=%h flag=%b want 1/40/001",
               rdr_a, tgt_a, flag_a);
    end
    idle();
    tick();
    checks++;
    if (rdr_a !== 0) begin
      errors++; $display("FAIL redirect_one_cycle: got %b want 0", rdr_a);
    end
    // Two consecutive branches give two pulses.
    ex_valid = 1; ex_branch = 1; ex_branch_target = 32'h80;
    tick();
    ex_branch_target = 32'hC0;
    checks++;
    if (rdr_a !== 1 || tgt_a !== 32'h80) begin
      errors++; $display("FAIL b2b_first: got rdr=%b tgt=%h want 1/80", rdr_a, tgt_a);
    end
    tick();
    checks++;
    if (rdr_a !== 1 || tgt_a !== 32'hC0) begin
      errors++; $display("FAIL b2b_second: got rdr=%b tgt=%h want 1/c0", rdr_a, tgt_a);
    end
    // CMP presenting 000 clears the flag register.
    idle(); ex_valid = 1; ex_flag = 3'b000; ex_flag_we = 1;
    tick();
    checks++;
    if (flag_a !== 3'b000) begin
      errors++; $display("FAIL cmp_clear: got %b want 000", flag_a);
    end
  endtask

  task automatic test_stall_flush();
    idle();
    ex_valid = 1; ex_branch = 1; ex_branch_target = 32'h200; stall = 1;
    tick(); tick();
    checks++;
    if (rdr_a !== 0) begin
      errors++; $display("FAIL stall_no_redirect: got %b want 0", rdr_a);
    end
    stall = 0;
    tick();
    checks++;
    if (rdr_a !== 1 || tgt_a !== 32'h200) begin
      errors++; $display("FAIL stall_release_redirect: got rdr=%b tgt=%h want 1/200", rdr_a, tgt_a);
    end
    // Hold the slot: the pulse must not repeat.
    stall = 1;
    tick();
    checks++;
    if (rdr_a !== 0 || mv_a !== 1) begin
      errors++; $display("FAIL stall_once: got rdr=%b v=%b want 0/1", rdr_a, mv_a);
    end
    idle();
    ex_valid = 1; ex_flag = 3'b101; ex_flag_we = 1; ex_reg_write = 1;
    stall = 1; flush = 1;
    tick();
    checks++;
    if (mv_a !== 0 || flag_a !== 3'b000 || rw_a !== 0) begin
      errors++;
      $display("FAIL flush_stall: got v=%b flag=%b rw=%b want 0/000/0", mv_a, flag_a, rw_a);
    end
  endtask

  task automatic test_overflow();
    idle(); reset = 1; tick(); reset = 0;
    ex_valid = 1; ex_flag = 3'b011; ex_flag_we = 1; ex_reg_write = 1;
    ex_result = 32'h7FFF_FFFF; ex_rd = 5'd3;
    tick();
    checks++;
    if (exc_a !== 1 || rw_a !== 0 || cnt_a !== 8'd1 || res_a !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL ovf_trap: got exc=%b rw=%b cnt=%0d res=%h want 1/0/1/7fffffff",
               exc_a, rw_a, cnt_a, res_a);
    end
    checks++;
    if (exc_b !== 0 || rw_b !== 1 || cnt_b !== 2'd1) begin
      errors++;
      $display("FAIL ovf_notrap: got exc=%b rw=%b cnt=%0d want 0/1/1", exc_b, rw_b, cnt_b);
    end
    ex_flag = 3'b100;
    tick();
    checks++;
    if (exc_a !== 1 || cnt_a !== 8'd2 || flag_a !== 3'b100) begin
      errors++;
      $display("FAIL udf_trap: got exc=%b cnt=%0d flag=%b want 1/2/100", exc_a, cnt_a, flag_a);
    end
    ex_flag = 3'b000; ex_flag_we = 0;
    tick();
    checks++;
    if (exc_a !== 0 || rw_a !== 1 || cnt_a !== 8'd2) begin
      errors++;
      $display("FAIL ovf_clear: got exc=%b rw=%b cnt=%0d want 0/1/2", exc_a, rw_a, cnt_a);
    end
  endtask

  task automatic test_saturation();
    idle(); reset = 1; tick(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1; ex_flag_we = 1; ex_flag = (i % 2 == 0) ? 3'b011 : 3'b100;
      tick();
    end
    checks++;
    if (cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
      errors++; $display("FAIL saturate: got b=%0d a=%0d want 3/5", cnt_b, cnt_a);
    end
    tick();
    checks++;
    if (cnt_b !== 2'd3) begin
      errors++; $display("FAIL saturate_nowrap: got %0d want 3", cnt_b);
    end
    reset = 1;
    tick();
    reset = 0; idle();
    checks++;
    if (cnt_b !== 2'd0 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL reset_count: got b=%0d a=%0d want 0/0", cnt_b, cnt_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 39) == 0);
      stall            = ($urandom_range(0, 4) == 0);
      flush            = ($urandom_range(0, 7) == 0);
      ex_valid         = ($urandom_range(0, 3) != 0);
      ex_result        = $urandom;
      ex_store_data    = $urandom;
      ex_pc            = $urandom;
      ex_branch_target = $urandom;
      ex_rd            = 5'($urandom);
      ex_reg_write     = 1'($urandom);
      ex_mem_read      = 1'($urandom);
      ex_mem_write     = 1'($urandom);
      ex_flag          = 3'($urandom_range(0, 5));
      ex_flag_we       = 1'($urandom);
      ex_branch        = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (mv_a !== m_a.valid || rw_a !== (m_a.valid & m_a.rw) ||
          mr_a !== (m_a.valid & m_a.mr) || mw_a !== (m_a.valid & m_a.mw) ||
          exc_a !== m_a.exc || flag_a !== m_a.flag || rdr_a !== m_a.redirect ||
          cnt_a !== 8'(m_a.cnt) || fv_a !== (m_a.valid & m_a.rw) ||
          (m_a.valid && (res_a !== m_a.result || st_a !== m_a.store || pc_a !== m_a.pc ||
                         rd_a !== m_a.rd || frd_a !== m_a.rd || fd_a !== m_a.result)) ||
          (m_a.redirect && tgt_a !== m_a.target)) begin
        errors++;
        $display("FAIL rand_a[%0d]: got v=%b rw=%b exc=%b flag=%b rdr=%b cnt=%0d res=%h want v=%b rw=%b exc=%b flag=%b rdr=%b cnt=%0d res=%h",
                 i, mv_a, rw_a, exc_a, flag_a, rdr_a, cnt_a, res_a,
                 m_a.valid, m_a.valid & m_a.rw, m_a.exc, m_a.flag, m_a.redirect, m_a.cnt, m_a.result);
      end
      checks++;
      if (mv_b !== m_b.valid || rw_b !== (m_b.valid & m_b.rw) || exc_b !== 1'b0 ||
          cnt_b !== 2'(m_b.cnt) || rdr_b !== m_b.redirect) begin
        errors++;
        $display("FAIL rand_b[%0d]: got v=%b rw=%b exc=%b cnt=%0d rdr=%b want v=%b rw=%b exc=0 cnt=%0d rdr=%b",
                 i, mv_b, rw_b, exc_b, cnt_b, rdr_b,
                 m_b.valid, m_b.valid & m_b.rw, m_b.cnt, m_b.redirect);
      end
    end
    reset = 0; idle();
  endtask

  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};
    reset = 1;
    idle();
    @(negedge clock);
    test_reset();
    test_pipeline();
    test_flag_branch();
    test_stall_flush();
    test_overflow();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
